alt_vipitc131_common_avalon_mm_csr_bank: RTL and testbench

//  Parametrised Avalon-MM control/status register bank for VIP cores (CVO, frame reader).

---
 rtl/alt_vipitc131_common_avalon_mm_csr_bank.sv | 166 ++++++++++++++++
 tb/tb_alt_vipitc131_common_avalon_mm_csr_bank.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alt_vipitc131_common_avalon_mm_csr_bank.sv
// Avalon-MM CSR bank for VIP cores: go bit, stopped status, sticky interrupts and user registers.
// Define ALT_VIPITC_MM_SHADOW_EN to shadow user registers and apply them on a frame-boundary commit.
module alt_vipitc131_common_avalon_mm_csr_bank #(
  parameter int unsigned AV_ADDRESS_WIDTH     = 6,
  parameter int unsigned AV_DATA_WIDTH        = 32,
  parameter int unsigned NO_OUTPUTS           = 1,
  parameter int unsigned NO_INTERRUPTS        = 2,
  parameter int unsigned NO_REGISTERS         = 8,
  parameter int unsigned READ_LATENCY         = 1,
  parameter int unsigned ALLOW_INTERNAL_WRITE = 0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [AV_ADDRESS_WIDTH-1:0]           av_address,
  input  logic                                  av_read,
  output logic [AV_DATA_WIDTH-1:0]              av_readdata,
  output logic                                  av_readdatavalid,
  input  logic                                  av_write,
  input  logic [AV_DATA_WIDTH-1:0]              av_writedata,
  input  logic [AV_DATA_WIDTH/8-1:0]            av_byteenable,
  output logic                                  av_irq,
  output logic                                  enable,
  input  logic                                  clear_enable,
  output logic [NO_REGISTERS-1:0]               triggers,
  output logic [AV_DATA_WIDTH*NO_REGISTERS-1:0] registers,
  input  logic [AV_DATA_WIDTH*NO_REGISTERS-1:0] registers_in,
  input  logic [NO_REGISTERS-1:0]               registers_write,
  input  logic [NO_INTERRUPTS-1:0]              interrupts,
  input  logic [NO_OUTPUTS-1:0]                 stopped,
  input  logic                                  commit
);

  localparam int unsigned W   = AV_DATA_WIDTH;
  localparam int unsigned NBE = AV_DATA_WIDTH / 8;
  localparam int unsigned NR  = NO_REGISTERS;
  localparam int unsigned NI  = NO_INTERRUPTS;
  localparam logic [W-1:0] CTRL_MASK = {{(W-NI-1){1'b0}}, {(NI+1){1'b1}}};
  localparam logic [W-1:0] PEND_MASK = {{(W-NI-1){1'b0}}, {NI{1'b1}}, 1'b0};

  logic [W-1:0]         wmask_c;
  logic [W-1:0]         ctrl_q, ctrl_d;
  logic [W-1:0]         pend_q, pend_d;
  logic [W-1:0]         rdata_c;
  logic [NR-1:0][W-1:0] user_q, user_d;
  logic [NR-1:0]        trig_d;
  logic                 user_wr_c;
  logic                 status_pending_c;
  logic                 wr_ctrl_c, wr_irq_c;

  // Byte lanes expanded to a bit mask
  always_comb begin
    wmask_c = '0;
    for (int unsigned b = 0; b < NBE; b++) wmask_c[b*8 +: 8] = {8{av_byteenable[b]}};
  end

  assign wr_ctrl_c = av_write && (av_address == AV_ADDRESS_WIDTH'(0));
  assign wr_irq_c  = av_write && (av_address == AV_ADDRESS_WIDTH'(2));

  // Control word and sticky interrupt pending bits; a new event beats a same-cycle W1C
  always_comb begin
    ctrl_d = ctrl_q;
    if (wr_ctrl_c) ctrl_d = ((ctrl_q & ~wmask_c) | (av_writedata & wmask_c)) & CTRL_MASK;
    if (!(wr_ctrl_c && av_byteenable[0]) && clear_enable) ctrl_d[0] = 1'b0;
    pend_d = pend_q;
    if (wr_irq_c) pend_d = pend_d & ~(av_writedata & wmask_c);
    pend_d = (pend_d | W'({interrupts, 1'b0})) & ctrl_q & PEND_MASK;
  end

  // User registers: master write has priority over internal load
  always_comb begin
    user_d    = user_q;
    trig_d    = '0;
    user_wr_c = 1'b0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (av_write && (av_address == AV_ADDRESS_WIDTH'(i + 3))) begin
        user_d[i] = (user_q[i] & ~wmask_c) | (av_writedata & wmask_c);
        trig_d[i] = 1'b1;
        user_wr_c = 1'b1;
      end else if ((ALLOW_INTERNAL_WRITE != 0) && registers_write[i]) begin
        user_d[i] = registers_in[i*W +: W];
        user_wr_c = 1'b1;
      end
    end
  end

  // Read mux on pre-write state
  always_comb begin
    rdata_c = '0;
    if (av_address == AV_ADDRESS_WIDTH'(0))      rdata_c = ctrl_q;
    else if (av_address == AV_ADDRESS_WIDTH'(1)) rdata_c = W'({status_pending_c, &stopped});
    else if (av_address == AV_ADDRESS_WIDTH'(2)) rdata_c = pend_q;
    for (int unsigned i = 0; i < NR; i++) begin
      if (av_address == AV_ADDRESS_WIDTH'(i + 3)) rdata_c = user_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q   <= '0;
      pend_q   <= '0;
      user_q   <= '0;
      triggers <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      pend_q   <= pend_d;
      user_q   <= user_d;
      triggers <= trig_d;
    end
  end

  assign enable = ctrl_q[0];
  assign av_irq = |pend_q;

  generate
    if (READ_LATENCY == 2) begin : g_rd2
      logic         rd_valid_q;
      logic [W-1:0] rd_data_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_valid_q       <= 1'b0;
          rd_data_q        <= '0;
          av_readdatavalid <= 1'b0;
          av_readdata      <= '0;
        end else begin
          rd_valid_q       <= av_read;
          av_readdatavalid <= rd_valid_q;
          if (av_read)    rd_data_q   <= rdata_c;
          if (rd_valid_q) av_readdata <= rd_data_q;
        end
      end
    end else begin : g_rd1
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          av_readdatavalid <= 1'b0;
          av_readdata      <= '0;
        end else begin
          av_readdatavalid <= av_read;
          if (av_read) av_readdata <= rdata_c;
        end
      end
    end
  endgenerate

`ifdef ALT_VIPITC_MM_SHADOW_EN
  // user_q acts as the shadow set; live_q is what the core sees
  logic [NR-1:0][W-1:0] live_q;
  logic                 pending_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live_q    <= '0;
      pending_q <= 1'b0;
    end else begin
      if (commit) live_q <= user_q;
      pending_q <= user_wr_c | (pending_q & ~commit);
    end
  end
  assign registers        = live_q;
  assign status_pending_c = pending_q;
`else
  logic unused_ok;
  assign unused_ok        = ^{commit, user_wr_c};
  assign registers        = user_q;
  assign status_pending_c = 1'b0;
`endif

endmodule

// File: tb/tb_alt_vipitc131_common_avalon_mm_csr_bank.sv
// Directed self-checking bench for the Avalon-MM CSR bank (READ_LATENCY=2, internal writes on).
module tb_alt_vipitc131_common_avalon_mm_csr_bank;
  localparam int unsigned AW  = 6;
  localparam int unsigned W   = 32;
  localparam int unsigned NR  = 8;
  localparam int unsigned NI  = 2;
  localparam int unsigned NO  = 1;
  localparam int unsigned LAT = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [AW-1:0]     av_address;
  logic              av_read;
  logic [W-1:0]      av_readdata;
  logic              av_readdatavalid;
  logic              av_write;
  logic [W-1:0]      av_writedata;
  logic [W/8-1:0]    av_byteenable;
  logic              av_irq;
  logic              enable;
  logic              clear_enable;
  logic [NR-1:0]     triggers;
  logic [W*NR-1:0]   registers;
  logic [W*NR-1:0]   registers_in;
  logic [NR-1:0]     registers_write;
  logic [NI-1:0]     interrupts;
  logic [NO-1:0]     stopped;
  logic              commit;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alt_vipitc131_common_avalon_mm_csr_bank #(
    .AV_ADDRESS_WIDTH(AW), .AV_DATA_WIDTH(W), .NO_OUTPUTS(NO), .NO_INTERRUPTS(NI),
    .NO_REGISTERS(NR), .READ_LATENCY(LAT), .ALLOW_INTERNAL_WRITE(1)
  ) dut (
    .clk(clk), .rst(rst), .av_address(av_address), .av_read(av_read),
    .av_readdata(av_readdata), .av_readdatavalid(av_readdatavalid), .av_write(av_write),
    .av_writedata(av_writedata), .av_byteenable(av_byteenable), .av_irq(av_irq),
    .enable(enable), .clear_enable(clear_enable), .triggers(triggers), .registers(registers),
    .registers_in(registers_in), .registers_write(registers_write), .interrupts(interrupts),
    .stopped(stopped), .commit(commit)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [W/8-1:0] be);
    av_address = a; av_writedata = d; av_byteenable = be; av_write = 1'b1;
    tick();
    av_write = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [AW-1:0] a, input logic [W-1:0] exp);
    int cnt;
    av_address = a; av_read = 1'b1;
    tick();
    av_read = 1'b0;
    cnt = 1;
    while (!av_readdatavalid && cnt < 6) begin
      tick();
      cnt++;
    end
    chk({tag, "_lat"}, 64'(cnt), 64'(LAT));
    chk(tag, 64'(av_readdata), 64'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; av_address = '0; av_read = 1'b0; av_write = 1'b0; av_writedata = '0;
    av_byteenable = '0; clear_enable = 1'b0; registers_in = '0; registers_write = '0;
    interrupts = '0; stopped = '0; commit = 1'b0;
    tick(); tick();
    chk("rst_enable", 64'(enable), 0);
    chk("rst_irq", 64'(av_irq), 0);
    chk("rst_rdv", 64'(av_readdatavalid), 0);
    chk("rst_rdata", 64'(av_readdata), 0);
    chk("rst_trig", 64'(triggers), 0);
    chk("rst_regs", 64'(|registers), 0);
    rst = 1'b0;
    tick();

    // Reset asserted one cycle into a read kills it and clears state
    wr(6'd0, 32'h7, 4'hF);
    wr(6'd3, 32'h1, 4'hF);
    chk("pre_rst_enable", 64'(enable), 1);
    av_address = 6'd0; av_read = 1'b1;
    tick();
    av_read = 1'b0; rst = 1'b1;
    tick(); tick();
    chk("midrst_rdv", 64'(av_readdatavalid), 0);
    chk("midrst_rdata", 64'(av_readdata), 0);
    chk("midrst_enable", 64'(enable), 0);
    chk("midrst_regs", 64'(|registers), 0);
    rst = 1'b0;
    tick();

    // Go bit and clear_enable
    wr(6'd0, 32'h7, 4'hF);
    chk("go_set", 64'(enable), 1);
    rd("ctrl_rd", 6'd0, 32'h7);
    clear_enable = 1'b1;
    tick();
    clear_enable = 1'b0;
    chk("go_clr", 64'(enable), 0);
    rd("ctrl_clr", 6'd0, 32'h6);
    clear_enable = 1'b1;
    wr(6'd0, 32'h7, 4'hF);
    clear_enable = 1'b0;
    chk("go_master_wins", 64'(enable), 1);
    wr(6'd0, 32'h0, 4'hE);
    rd("ctrl_lane_off", 6'd0, 32'h7);

    // Status
    stopped = 1'b1;
    rd("status_stop", 6'd1, 32'h1);
    stopped = 1'b0;
    rd("status_run", 6'd1, 32'h0);

    // Interrupts
    interrupts = 2'b10;
    tick();
    interrupts = 2'b00;
    chk("irq_line", 64'(av_irq), 1);
    rd("irq_pend", 6'd2, 32'h4);
    interrupts = 2'b10;
    wr(6'd2, 32'h4, 4'hF);
    interrupts = 2'b00;
    chk("irq_setwins_line", 64'(av_irq), 1);
    rd("irq_setwins", 6'd2, 32'h4);
    wr(6'd2, 32'h4, 4'hF);
    chk("irq_w1c_line", 64'(av_irq), 0);
    rd("irq_w1c", 6'd2, 32'h0);
    interrupts = 2'b11;
    tick();
    interrupts = 2'b00;
    rd("irq_both", 6'd2, 32'h6);
    wr(6'd2, 32'h6, 4'h0);
    rd("irq_w1c_lane_off", 6'd2, 32'h6);
    wr(6'd0, 32'h1, 4'hF);
    tick();
    chk("irq_disable_line", 64'(av_irq), 0);
    rd("irq_disable", 6'd2, 32'h0);
    interrupts = 2'b11;
    tick();
    interrupts = 2'b00;
    tick();
    chk("irq_masked", 64'(av_irq), 0);

    // User registers with byte enables and triggers
    wr(6'd3, 32'hAABBCCDD, 4'hF);
    chk("trig_reg3", 64'(triggers), 64'h01);
    tick();
    chk("trig_reg3_drop", 64'(triggers), 0);
    wr(6'd3, 32'h11223344, 4'h5);
    chk("trig_reg3_be", 64'(triggers), 64'h01);
`ifndef ALT_VIPITC_MM_SHADOW_EN
    chk("regs0_be", 64'(registers[31:0]), 64'hAA22CC44);
`endif
    rd("reg3_be", 6'd3, 32'hAA22CC44);

    registers_in[63:32] = 32'hDEADBEEF; registers_write = 8'h02;
    tick();
    registers_write = '0;
    chk("trig_internal", 64'(triggers), 0);
    rd("reg4_internal", 6'd4, 32'hDEADBEEF);
    registers_in[63:32] = 32'hCAFEF00D; registers_write = 8'h02;
    wr(6'd4, 32'h12345678, 4'hF);
    registers_write = '0;
    chk("trig_master_wins", 64'(triggers), 64'h02);
`ifndef ALT_VIPITC_MM_SHADOW_EN
    chk("regs1_master", 64'(registers[63:32]), 64'h12345678);
`endif
    rd("reg4_master", 6'd4, 32'h12345678);

    wr(6'd10, 32'hFFFF0000, 4'hC);
    chk("trig_reg10", 64'(triggers), 64'h80);
    rd("reg10", 6'd10, 32'hFFFF0000);
    wr(6'd11, 32'hFFFFFFFF, 4'hF);
    chk("trig_unmapped", 64'(triggers), 0);
    rd("unmapped11", 6'd11, 32'h0);
    rd("unmapped63", 6'd63, 32'h0);

    // Read and write same address in same cycle returns old data
    av_address = 6'd3; av_writedata = 32'h55; av_byteenable = 4'hF;
    av_write = 1'b1; av_read = 1'b1;
    tick();
    av_write = 1'b0; av_read = 1'b0;
    tick();
    chk("raw_rdv", 64'(av_readdatavalid), 1);
    chk("raw_old", 64'(av_readdata), 64'hAA22CC44);
    rd("raw_new", 6'd3, 32'h55);

    // Back-to-back reads, then readdata holds
    av_read = 1'b1; av_address = 6'd3;
    tick();
    av_address = 6'd4;
    tick();
    av_read = 1'b0;
    chk("b2b0_rdv", 64'(av_readdatavalid), 1);
    chk("b2b0_data", 64'(av_readdata), 64'h55);
    tick();
    chk("b2b1_rdv", 64'(av_readdatavalid), 1);
    chk("b2b1_data", 64'(av_readdata), 64'h12345678);
    tick();
    chk("b2b_idle_rdv", 64'(av_readdatavalid), 0);
    chk("b2b_hold", 64'(av_readdata), 64'h12345678);

    // Commit behaviour
`ifdef ALT_VIPITC_MM_SHADOW_EN
    commit = 1'b1;
    tick();
    commit = 1'b0;
    chk("shadow_sync", 64'(registers[31:0]), 64'h55);
    wr(6'd3, 32'h5, 4'hF);
    tick();
    chk("shadow_hold", 64'(registers[31:0]), 64'h55);
    rd("shadow_pending", 6'd1, 32'h2);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    chk("shadow_commit", 64'(registers[31:0]), 64'h5);
    rd("shadow_clear", 6'd1, 32'h0);
`else
    wr(6'd3, 32'h5, 4'hF);
    chk("direct_update", 64'(registers[31:0]), 64'h5);
    rd("direct_status", 6'd1, 32'h0);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    chk("commit_ignored", 64'(registers[31:0]), 64'h5);
    rd("reg3_commit", 6'd3, 32'h5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
